// File: rtl/demux_dispatch_ctrl.sv
// Dispatch controller for a 1:N demux: accepts one payload bit, picks a channel
// (round-robin or directed), then strobes it onto the demux for one cycle.
module demux_dispatch_ctrl #(
  parameter  int SEL_W = 3,
  localparam int NCH   = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_data,
  input  logic [SEL_W-1:0] in_dest,
  input  logic             mode,
  input  logic [NCH-1:0]   ch_en,
  input  logic [NCH-1:0]   ch_ready,
  output logic [SEL_W-1:0] sel,
  output logic             din,
  output logic [NCH-1:0]   out_valid,
  output logic             busy,
  output logic             drop_err
);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_SEND} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               din_q, din_d;
  logic [NCH-1:0]     out_valid_q, out_valid_d;
  logic               drop_err_q, drop_err_d;
  logic               busy_q, busy_d;
  logic               in_ready_q, in_ready_d;

  logic               data_q, data_d;
  logic [SEL_W-1:0]   dest_q, dest_d;
  logic               mode_q, mode_d;

  logic               rr_found;
  logic [SEL_W-1:0]   rr_idx;
  logic [SEL_W-1:0]   rr_probe;
  logic               cand_ok;
  logic [SEL_W-1:0]   cand_idx;

  // First enabled-and-ready channel at or after ptr, wrapping modulo NCH.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    rr_probe = ptr_q;
    for (int k = 0; k < NCH; k++) begin
      rr_probe = ptr_q + SEL_W'(k);
      if (!rr_found && ch_en[rr_probe] && ch_ready[rr_probe]) begin
        rr_found = 1'b1;
        rr_idx   = rr_probe;
      end
    end
  end

  always_comb begin
    if (mode_q) begin
      cand_ok  = ch_en[dest_q] && ch_ready[dest_q];
      cand_idx = dest_q;
    end else begin
      cand_ok  = rr_found;
      cand_idx = rr_idx;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    din_d       = 1'b0;
    out_valid_d = '0;
    drop_err_d  = 1'b0;
    data_d      = data_q;
    dest_d      = dest_q;
    mode_d      = mode_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          data_d  = in_data;
          dest_d  = in_dest;
          mode_d  = mode;
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        if (mode_q && !ch_en[dest_q]) begin
          drop_err_d = 1'b1;
          state_d    = S_IDLE;
        end else if (cand_ok) begin
          sel_d       = cand_idx;
          din_d       = data_q;
          out_valid_d = NCH'(1) << cand_idx;
          state_d     = S_SEND;
          if (!mode_q) ptr_d = cand_idx + SEL_W'(1);
        end
      end
      S_SEND:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      din_q       <= 1'b0;
      out_valid_q <= '0;
      drop_err_q  <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      din_q       <= din_d;
      out_valid_q <= out_valid_d;
      drop_err_q  <= drop_err_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // NOTE: the latched item needs no reset; it is only read after a fresh acceptance overwrites it.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    dest_q <= dest_d;
    mode_q <= mode_d;
  end

  assign in_ready  = in_ready_q;
  assign sel       = sel_q;
  assign din       = din_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign drop_err  = drop_err_q;

endmodule

// File: doc/demux_dispatch_ctrl.md
DEMUX_DISPATCH_CTRL -- requirements
Module: demux_dispatch_ctrl

Interface
REQ-001 Parameter: SEL_W, 3, select width; channel count NCH = 2**SEL_W = 8.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  upstream item available.
REQ-005 Port: in_ready  output  1  block can accept an item.
REQ-006 Port: in_data  input  1  payload bit, to be routed to one channel.
REQ-007 Port: in_dest  input  SEL_W  target channel; used only when mode=1.
REQ-008 Port: mode  input  1  0 = round-robin dispatch, 1 = directed dispatch.
REQ-009 Port: ch_en  input  NCH  per-channel enable mask.
REQ-010 Port: ch_ready  input  NCH  per-channel sink ready.
REQ-011 Port: sel  output  SEL_W  select driven to the 1:8 demux.
REQ-012 Port: din  output  1  data driven to the 1:8 demux.
REQ-013 Port: out_valid  output  NCH  one-hot strobe marking the channel receiving din.
REQ-014 Port: busy  output  1  high whenever the state is not IDLE.
REQ-015 Port: drop_err  output  1  one-cycle pulse when a directed item is discarded.

Function
REQ-016 The FSM SHALL have three states: IDLE, ARB, SEND; all outputs SHALL be registered.
REQ-017 In IDLE, in_ready SHALL be 1; it SHALL be 0 in ARB and SEND.
REQ-018 When in_valid=1 and in_ready=1 at edge N, the block SHALL latch in_data, in_dest, and mode, and SHALL enter ARB.
REQ-019 ARB, mode=0: every cycle, search indices ptr, ptr+1, ... (mod 8) for the first i with ch_en[i]=1 and ch_ready[i]=1.
REQ-020 ARB, mode=1: the only candidate SHALL be i = latched in_dest.
REQ-021 ARB, candidate found: at the next edge, sel<=i, din<=latched data, out_valid<=onehot(i), and the state SHALL go to SEND.
REQ-022 ARB, no candidate: the block SHALL remain in ARB with out_valid=0; ch_en and ch_ready SHALL be re-sampled every cycle; there is no timeout.
REQ-023 ARB, mode=1 and ch_en[in_dest]=0: drop_err=1 for exactly one cycle, the item SHALL be discarded, and the state SHALL go to IDLE with no out_valid.
REQ-024 SEND SHALL last exactly one cycle, then return to IDLE; minimum latency is acceptance at edge N, out_valid high in cycle N+2; maximum throughput is one item per 3 cycles.
REQ-025 On leaving SEND, out_valid SHALL be 0 and din SHALL be 0; sel SHALL hold its last value.
REQ-026 ptr SHALL update to (i+1) mod 8 only on a mode=0 grant, so that 7 wraps to 0; directed grants SHALL leave ptr unchanged.
REQ-027 out_valid SHALL be zero or one-hot at all times, and SHALL always equal onehot(sel) when nonzero.
REQ-028 Changes to mode or in_dest after acceptance SHALL NOT affect the pending item.

Reset
REQ-029 When rst=1 at an edge: state=IDLE, ptr=0, sel=0, din=0, out_valid=0, drop_err=0, busy=0, and in_ready=0 during the reset cycle.
REQ-030 in_ready SHALL go to 1 in the first cycle after rst deasserts.
REQ-031 Reset in ARB or SEND SHALL discard the pending item; out_valid SHALL be 0 from the next edge.
REQ-032 rst SHALL take priority over in_valid in the same cycle.

Verification
REQ-033 Round-robin sweep: mode=0, ch_en=ch_ready=8'hFF, 8 items in_data=1 back-to-back -> sel 0,1,...,7 in order, out_valid 8'h01..8'h80, then a 9th item -> sel=0 (wrap).
REQ-034 Skip busy channels: mode=0, ptr=2, ch_ready=8'b1000_0001 -> grant sel=7; next item -> sel=0.
REQ-035 Directed stall: mode=1, in_dest=6, ch_ready[6]=0 for 5 cycles then 1 -> busy=1 and out_valid=0 throughout the stall; then out_valid=8'h40 and din=in_data for one cycle.
REQ-036 Directed drop: mode=1, in_dest=3, ch_en[3]=0 -> drop_err=1 for one cycle, out_valid stays 0, in_ready=1 on the following cycle.
REQ-037 Reset mid-operation: accept an item with ch_ready=0, assert rst in ARB -> out_valid=0, sel=0, ptr=0, no grant after ch_ready rises.
REQ-038 Data zero: in_data=0, mode=0 -> out_valid is one-hot and din=0, confirming the strobe is independent of payload.
